rdptr_empty_fwft: RTL and testbench

Read-side pointer, empty-flag and first-word-fall-through (FWFT) output block for the dual-clock FIFO. It is the counterpart of the write-pointer/full-flag logic and sits entirely in the read clock domain. It owns the binary read pointer that the write side compares for its full flag, and it drives the read port of the FIFO memory (synchronous, 1-cycle read latency). It presents data to the consumer through a valid/ready handshake backed by a 2-entry prefetch buffer.

---
 rtl/rdptr_empty_fwft.sv | 87 ++++++++
 tb/tb_rdptr_empty_fwft.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdptr_empty_fwft.sv
// Read-domain pointer, empty/almost-empty flags and a 2-entry first-word-fall-through
// output buffer sitting in front of a synchronous (1-cycle latency) FIFO memory.
module rdptr_empty_fwft #(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 2
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rst_n,
  input  logic [PTR_WIDTH:0]    i_wrptr_sync,
  output logic [PTR_WIDTH:0]    o_rdptr,
  output logic [PTR_WIDTH-1:0]  o_rdaddr,
  output logic                  o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_empty_flag,
  output logic                  o_almost_empty,
  output logic [PTR_WIDTH+1:0]  o_level
);

  localparam logic [PTR_WIDTH+1:0] AE_LVL = AE_THRESH[PTR_WIDTH+1:0];

  logic [PTR_WIDTH:0]    rdptr_q, rdptr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic                  pop;
  logic                  rd_en;
  logic [1:0]            occ;
  logic [1:0]            after_pop;
  logic [PTR_WIDTH:0]    mem_words;

  assign o_empty_flag = (i_wrptr_sync == rdptr_q);
  assign o_rd_valid   = (count_q != 2'd0);
  assign pop          = o_rd_valid && i_rd_ready;

  // Buffer slots already spoken for: held words plus the read coming back this cycle.
  assign occ       = count_q + {1'b0, inflight_q};
  assign after_pop = count_q - {1'b0, pop};
  assign rd_en     = !o_empty_flag && ((occ < 2'd2) || pop);

  assign mem_words      = i_wrptr_sync - rdptr_q;
  assign o_level        = {1'b0, mem_words}
                        + {{(PTR_WIDTH+1){1'b0}}, inflight_q}
                        + {{PTR_WIDTH{1'b0}}, count_q};
  assign o_almost_empty = (o_level <= AE_LVL);

  assign o_rdptr     = rdptr_q;
  assign o_rdaddr    = rdptr_q[PTR_WIDTH-1:0];
  assign o_mem_rd_en = rd_en;
  assign o_rd_data   = head_q;

  always_comb begin
    rdptr_d    = rd_en ? rdptr_q + 1'b1 : rdptr_q;
    inflight_d = rd_en;
    count_d    = after_pop + {1'b0, inflight_q};
    head_d     = head_q;
    skid_d     = skid_q;
    if (pop) head_d = skid_q;
    // Returning word lands in the head only if nothing older will remain in the buffer.
    if (inflight_q) begin
      if (after_pop == 2'd0) head_d = i_mem_rdata;
      else                   skid_d = i_mem_rdata;
    end
  end

  always_ff @(posedge i_rd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdptr_q    <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      rdptr_q    <= rdptr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_rdptr_empty_fwft.sv
// Directed + randomized bench for rdptr_empty_fwft: memory model, word-order queue as reference.
module tb_rdptr_empty_fwft;
  localparam int PW = 3;
  localparam int DW = 8;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW:0]   wrptr = '0;
  logic [PW:0]   rdptr;
  logic [PW-1:0] rdaddr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          empty_flag;
  logic          almost_empty;
  logic [PW+1:0] level;

  rdptr_empty_fwft #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(AE)) dut (
    .i_rd_clk(clk), .i_rst_n(rst_n), .i_wrptr_sync(wrptr), .o_rdptr(rdptr),
    .o_rdaddr(rdaddr), .o_mem_rd_en(mem_rd_en), .i_mem_rdata(mem_rdata),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_empty_flag(empty_flag), .o_almost_empty(almost_empty), .o_level(level)
  );

  always #5 clk = ~clk;

  // FIFO storage with a registered read port
  logic [DW-1:0] mem [8];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[rdaddr];

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  logic [PW:0]   wp = '0;
  bit            popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [DW-1:0] d);
    mem[wp[PW-1:0]] = d;
    q.push_back(d);
    wp = wp + 1'b1;
    wrptr = wp;
  endtask

  // Reference: every word written and not yet consumed is in q, oldest first.
  task automatic sample();
    @(negedge clk);
    popped = 1'b0;
    check("level", 32'(level), 32'(q.size()));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    if (rd_valid) begin
      if (q.size() == 0) check("valid_without_data", 32'(rd_valid), 32'd0);
      else begin
        check("rd_data_order", 32'(rd_data), 32'(q[0]));
        if (rd_ready) begin
          void'(q.pop_front());
          popped = 1'b1;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    wp = '0;
    wrptr = '0;
    rd_ready = 1'b0;
    #1;
    check("rst_rdptr", 32'(rdptr), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_empty", 32'(empty_flag), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  initial begin
    int k, first, last, npops, nrd;
    bit seen;
    logic [DW-1:0] w0;

    // reset and idle empty
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("idle_rd_en", 32'(mem_rd_en), 32'd0);
      check("idle_empty", 32'(empty_flag), 32'd1);
      check("idle_rdptr", 32'(rdptr), 32'd0);
      advance();
    end

    // single word, latency t -> t+2
    put_word(8'hA5);
    rd_ready = 1'b1;
    sample();
    check("sw_rd_en_t", 32'(mem_rd_en), 32'd1);
    check("sw_addr_t", 32'(rdaddr), 32'd0);
    check("sw_valid_t", 32'(rd_valid), 32'd0);
    advance();
    sample();
    check("sw_valid_t1", 32'(rd_valid), 32'd0);
    advance();
    sample();
    check("sw_valid_t2", 32'(rd_valid), 32'd1);
    check("sw_data_t2", 32'(rd_data), 32'hA5);
    check("sw_pop_t2", 32'(popped), 32'd1);
    advance();
    sample();
    check("sw_rdptr", 32'(rdptr), 32'd1);
    check("sw_level", 32'(level), 32'd0);
    advance();

    // streaming across the address wrap
    do_reset();
    rd_ready = 1'b1;
    k = 0; first = -1; last = -1; npops = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 12) put_word(8'($urandom));
      sample();
      if (mem_rd_en) begin
        check("stream_addr", 32'(rdaddr), 32'(k % 8));
        k++;
      end
      if (popped) begin
        if (first < 0) first = c;
        last = c;
        npops++;
      end
      advance();
    end
    check("stream_reads", 32'(k), 32'd12);
    check("stream_pops", 32'(npops), 32'd12);
    check("stream_no_gap", 32'(last - first), 32'd11);
    check("stream_rdptr", 32'(rdptr), 32'b1100);

    // backpressure: two reads, then hold
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_word(8'($urandom));
    w0 = q[0];
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (mem_rd_en) nrd++;
      advance();
    end
    sample();
    check("bp_reads", 32'(nrd), 32'd2);
    check("bp_rd_en_held", 32'(mem_rd_en), 32'd0);
    check("bp_rdptr", 32'(rdptr), 32'd2);
    check("bp_level", 32'(level), 32'd8);
    check("bp_head", 32'(rd_data), 32'(w0));
    advance();
    rd_ready = 1'b1;
    first = -1; last = -1; npops = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (c == 0) check("bp_first_ready_read", 32'(mem_rd_en), 32'd1);
      if (popped) begin
        if (first < 0) first = c;
        last = c;
        npops++;
      end
      advance();
    end
    check("bp_pops", 32'(npops), 32'd8);
    check("bp_first_pop", 32'(first), 32'd0);
    check("bp_last_pop", 32'(last), 32'd7);
    sample();
    check("bp_empty", 32'(empty_flag), 32'd1);
    advance();

    // almost-empty while draining five words
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) put_word(8'($urandom));
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (seen) check("ae_stays_high", 32'(almost_empty), 32'd1);
      if (almost_empty) seen = 1'b1;
      advance();
    end
    check("ae_seen", 32'(seen), 32'd1);

    // asynchronous reset with a word buffered and one in flight
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) put_word(8'($urandom));
    sample(); advance();
    sample(); advance();
    sample();
    check("mid_valid_before", 32'(rd_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(rd_valid), 32'd0);
    check("mid_async_rdptr", 32'(rdptr), 32'd0);
    check("mid_async_data", 32'(rd_data), 32'd0);
    q.delete();
    wp = '0;
    wrptr = '0;
    advance();
    advance();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      check("mid_no_stale_valid", 32'(rd_valid), 32'd0);
      advance();
    end
    put_word(8'h3C);
    npops = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (popped) npops++;
      advance();
    end
    check("mid_new_word", 32'(npops), 32'd1);

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rd_ready = ($urandom % 4) != 0;
      if (q.size() < 8 && ($urandom % 3) != 0) put_word(8'($urandom));
      sample();
      advance();
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      sample();
      advance();
    end
    sample();
    check("rand_drain_level", 32'(level), 32'd0);
    check("rand_drain_empty", 32'(empty_flag), 32'd1);
    check("rand_drain_valid", 32'(rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
